wb_trace_capture: RTL and testbench
===================================

# wb_trace_capture

Debug trace capture unit that sits beside the pipelined RISC-V datapath. It consumes the datapath's debug taps:

- the writeback tap: `reg_write_sig`, `reg_num`, `reg_data`;
- the data-memory tap: `wr`, `addr`, `wr_data`.

Each architecturally visible event is timestamped and queued in a FIFO. A valid/ready stream drains the FIFO to a testbench monitor or an on-chip logger. It gives the verification team an in-order commit log, so they do not have to probe the datapath internals.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥4.
- `DATA_W`, 32: data field width.
- `DM_ADDRESS`, 9: address field width; must be ≥5.
- `TS_W`, 16: timestamp width.

Ports:
- `clk`  in  1  clock; everything on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `capture_en`  in  1  when low, no event is enqueued.
- `reg_write_sig`  in  1  writeback tap: register write strobe.
- `reg_num`  in  5  writeback tap: destination register.
- `reg_data`  in  `DATA_W`  writeback tap: value written.
- `wr`  in  1  memory tap: store strobe.
- `addr`  in  `DM_ADDRESS`  memory tap: store address.
- `wr_data`  in  `DATA_W`  memory tap: store data.
- `trace_valid`  out  1  head entry available.
- `trace_ready`  in  1  consumer accepts the head entry.
- `trace_kind`  out  1  0 = register write, 1 = memory store.
- `trace_tag`  out  `DM_ADDRESS`  `reg_num` zero-extended, or `addr`.
- `trace_data`  out  `DATA_W`  written value.
- `trace_ts`  out  `TS_W`  timestamp of the event.
- `level`  out  $clog2(`DEPTH`)+1  current occupancy.
- `drop_count`  out  16  events lost to overflow; saturating.

## Operation
- **Free-running timestamp counter `ts`**
  - 0 in the first cycle after reset deasserts.
  - Increments every cycle and wraps modulo 2^`TS_W`.
- **Event qualification** (only when `capture_en` is 1)
  - Register event: `reg_write_sig` && `reg_num` != 0. Writes to x0 are silently filtered and are not counted as drops.
  - Memory event: `wr`.
- **Entry contents:** {kind, tag, data, `ts` of the cycle the event was sampled}.
- **Push rules.** Let `free` = `DEPTH` − `level`, evaluated before this cycle's pop. A pop in the same cycle does not free space.
  - Both events present, `free` ≥ 2: the register event goes to the tail and the memory event to tail+1. This preserves commit order: WB is older than the MEM-stage store.
  - Both present, `free` = 1: the register event is enqueued; the memory event is dropped and `drop_count` += 1.
  - Both present, `free` = 0: both are dropped and `drop_count` += 2. Saturate at 16'hFFFF; adding 2 at 16'hFFFE yields 16'hFFFF.
  - Exactly one event present: enqueued if `free` ≥ 1, otherwise dropped with +1.
- **Pop:** occurs when `trace_valid` && `trace_ready`; the read pointer advances by 1.
- **Occupancy:** `level` next = `level` + pushes − pop. Push and pop may occur in the same cycle.
- **Pointers:** `DEPTH` is a power of two, so the pointers wrap naturally. `level` distinguishes full from empty.
- **Output contract:**
  - `trace_valid` = (`level` != 0).
  - Head outputs are driven combinationally from the storage at the read pointer.
  - Head outputs must stay stable while `trace_valid` && !`trace_ready`.
- **Reset:**
  - All pointers, `level`, `drop_count` and `ts` are cleared to 0.
  - `trace_valid` is 0. `trace_kind`, `trace_tag`, `trace_data` and `trace_ts` read 0: the storage is cleared on reset.
  - Events present during a reset cycle are not captured.
  - Reset mid-drain discards all queued entries; no partial transfer survives.

## Timing
- An event sampled at edge N is visible at the head (if the FIFO was empty) after edge N, with `trace_valid` = 1 in cycle N+1. Latency is 1 cycle.
- For a dual event, the register entry shows first. The memory entry follows the cycle after the register entry is accepted.
- Steady state: one entry popped per cycle while `trace_ready` is held high. Burst intake: up to 2 entries per cycle.
- `drop_count` and `level` update at the same edge as the push decision.
- No combinational path from `trace_ready` to any output other than through registered state.

## Structure
- Package `trace_pkg` holds:
  - `trace_kind_e` (`TR_REG`=0, `TR_MEM`=1);
  - the packed struct `trace_entry_t` {kind, tag, data, ts};
  - localparam `DROP_W`=16.
- Sub-module `trace_fifo_mem`: a `DEPTH`×`trace_entry_t` register array with two write ports (at `wptr` and `wptr+1`), one combinational read port and a synchronous clear.
- Top level: pointer, occupancy, push arbitration, drop counter and timestamp logic.

## Test plan
- **Basic capture:** after reset, in cycle 3, apply `reg_write_sig`=1, `reg_num`=5, `reg_data`=32'hDEADBEEF; hold `trace_ready`=0. Required: cycle 4 has `trace_valid`=1, kind=0, tag=5, data=DEADBEEF, ts=3, `level`=1.
- **x0 filter and enable:** a write to `reg_num`=0, and `wr`=1 while `capture_en`=0. Required: `level` stays 0 and `drop_count` stays 0.
- **Dual event ordering:** in the same cycle, reg x7←0x11 and store `addr`=0x40 data 0x22; `trace_ready`=1. Required: two consecutive transfers, first {0,7,0x11}, then {1,0x40,0x22}, with equal ts.
- **Overflow:** with `trace_ready`=0, push 15 single events, then one dual event. Required: `level`=16, `drop_count`=1, and the last entry is the register event. A further dual event gives `drop_count`=3.
- **Backpressure and wrap:** stream 40 events while `trace_ready` toggles pseudo-randomly. Required: every entry is received in order with no loss (`drop_count`=0), and the head is stable across stalled cycles.
- **Reset mid-drain:** with `level`=6 and `trace_ready`=1, assert `reset` for 1 cycle. Required: next cycle `trace_valid`=0, `level`=0, `drop_count`=0, and `ts` restarts at 0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the writeback/store trace capture unit.
// The entry field widths are fixed here, so instances of wb_trace_capture must use the same widths.
package trace_pkg;

    localparam int DROP_W    = 16;
    localparam int TR_DATA_W = 32;
    localparam int TR_TAG_W  = 9;
    localparam int TR_TS_W   = 16;

    typedef enum logic {
        TR_REG = 1'b0,
        TR_MEM = 1'b1
    } trace_kind_e;

    typedef struct packed {
        trace_kind_e           kind;
        logic [TR_TAG_W-1:0]   tag;
        logic [TR_DATA_W-1:0]  data;
        logic [TR_TS_W-1:0]    ts;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace entry storage: two adjacent write ports (waddr, waddr+1), one combinational read port
// and a synchronous clear, so reset leaves every head field reading zero.
module trace_fifo_mem
    import trace_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] waddr,
    input  trace_entry_t  wdata0,
    input  trace_entry_t  wdata1,
    input  logic [AW-1:0] raddr,
    output trace_entry_t  rdata
);

    trace_entry_t  mem_q [DEPTH];
    trace_entry_t  mem_d [DEPTH];
    logic [AW-1:0] waddr1;

    always_comb begin
        waddr1 = waddr + AW'(1);
        mem_d  = mem_q;
        if (we0) mem_d[waddr]  = wdata0;
        if (we1) mem_d[waddr1] = wdata1;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/wb_trace_capture.sv
// Timestamped commit log of register writebacks and memory stores, drained over valid/ready.
// Handles pointers, occupancy, two-event push arbitration, saturating drop count and timestamp.
module wb_trace_capture
    import trace_pkg::*;
#(
    parameter int  DEPTH      = 16,
    parameter int  DATA_W     = 32,
    parameter int  DM_ADDRESS = 9,
    parameter int  TS_W       = 16,
    localparam int AW         = $clog2(DEPTH),
    localparam int LVL_W      = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  capture_en,
    input  logic                  reg_write_sig,
    input  logic [4:0]            reg_num,
    input  logic [DATA_W-1:0]     reg_data,
    input  logic                  wr,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  trace_valid,
    input  logic                  trace_ready,
    output logic                  trace_kind,
    output logic [DM_ADDRESS-1:0] trace_tag,
    output logic [DATA_W-1:0]     trace_data,
    output logic [TS_W-1:0]       trace_ts,
    output logic [LVL_W-1:0]      level,
    output logic [DROP_W-1:0]     drop_count
);

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LVL_W-1:0]  level_q, level_d, free;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [DROP_W:0]   drop_sum;
    logic              reg_ev, mem_ev, pop, we0, we1;
    logic [1:0]        push_cnt, drop_inc;
    trace_entry_t      reg_entry, mem_entry, wdata0, head;

    always_comb begin
        reg_ev    = capture_en && reg_write_sig && (reg_num != 5'd0);
        mem_ev    = capture_en && wr;
        // Space is judged before this cycle's pop; a same-cycle pop never makes room.
        free      = LVL_W'(DEPTH) - level_q;
        pop       = (level_q != '0) && trace_ready;
        reg_entry = '{kind: TR_REG, tag: DM_ADDRESS'(reg_num), data: reg_data, ts: ts_q};
        mem_entry = '{kind: TR_MEM, tag: addr, data: wr_data, ts: ts_q};
        push_cnt  = 2'd0;
        drop_inc  = 2'd0;
        if (reg_ev && mem_ev) begin
            if (free >= LVL_W'(2)) begin
                push_cnt = 2'd2;
            end else if (free == LVL_W'(1)) begin
                push_cnt = 2'd1;
                drop_inc = 2'd1;
            end else begin
                drop_inc = 2'd2;
            end
        end else if (reg_ev || mem_ev) begin
            if (free != '0) push_cnt = 2'd1;
            else            drop_inc = 2'd1;
        end
        // The register event is older than the store, so it always takes the tail slot.
        we0      = (push_cnt != 2'd0);
        we1      = (push_cnt == 2'd2);
        wdata0   = reg_ev ? reg_entry : mem_entry;
        wptr_d   = wptr_q + AW'(push_cnt);
        rptr_d   = rptr_q + AW'(pop);
        level_d  = level_q + LVL_W'(push_cnt) - LVL_W'(pop);
        drop_sum = {1'b0, drop_q} + (DROP_W + 1)'(drop_inc);
        drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        ts_d     = ts_q + TS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            drop_q  <= '0;
        end else begin
            ts_q    <= ts_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            drop_q  <= drop_d;
        end
    end

    trace_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk    (clk),
        .clr    (reset),
        .we0    (we0),
        .we1    (we1),
        .waddr  (wptr_q),
        .wdata0 (wdata0),
        .wdata1 (mem_entry),
        .raddr  (rptr_q),
        .rdata  (head)
    );

    assign trace_valid = (level_q != '0);
    assign trace_kind  = head.kind;
    assign trace_tag   = head.tag;
    assign trace_data  = head.data;
    assign trace_ts    = head.ts;
    assign level       = level_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_wb_trace_capture.sv
// Scenario bench for wb_trace_capture against a queue-based model of the trace log.
module tb_wb_trace_capture;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset, capture_en, reg_write_sig, wr, trace_ready;
    logic [4:0]  reg_num;
    logic [31:0] reg_data, wr_data, trace_data;
    logic [8:0]  addr, trace_tag;
    logic        trace_valid, trace_kind;
    logic [15:0] trace_ts, drop_count;
    logic [4:0]  level;

    typedef struct {
        bit          kind;
        logic [8:0]  tag;
        logic [31:0] data;
        logic [15:0] ts;
    } ent_t;

    ent_t mq[$];
    int   m_ts, m_drop;
    int   n_vec, n_err;

    wb_trace_capture #(.DEPTH(DEPTH), .DATA_W(32), .DM_ADDRESS(9), .TS_W(16)) dut (
        .clk(clk), .reset(reset), .capture_en(capture_en),
        .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
        .wr(wr), .addr(addr), .wr_data(wr_data),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_kind(trace_kind), .trace_tag(trace_tag), .trace_data(trace_data),
        .trace_ts(trace_ts), .level(level), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Model advances on the current inputs, then the clock edge happens.
    task automatic tick();
        int free;
        bit re, me;
        if (reset) begin
            mq.delete();
            m_ts   = 0;
            m_drop = 0;
        end else begin
            free = DEPTH - mq.size();
            re   = capture_en && reg_write_sig && (reg_num != 0);
            me   = capture_en && wr;
            if (mq.size() != 0 && trace_ready) void'(mq.pop_front());
            if (re) begin
                if (free >= 1) begin mq.push_back('{1'b0, 9'(reg_num), reg_data, 16'(m_ts)}); free--; end
                else m_drop++;
            end
            if (me) begin
                if (free >= 1) mq.push_back('{1'b1, addr, wr_data, 16'(m_ts)});
                else m_drop++;
            end
            if (m_drop > 65535) m_drop = 65535;
            m_ts = (m_ts + 1) % 65536;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        capture_en = 1'b1; reg_write_sig = 1'b0; wr = 1'b0;
        reg_num = 5'd0; reg_data = '0; addr = '0; wr_data = '0;
    endtask

    task automatic set_single(input bit is_mem);
        clear_in();
        if (is_mem) begin
            wr = 1'b1; addr = 9'($urandom); wr_data = $urandom;
        end else begin
            reg_write_sig = 1'b1; reg_num = 5'($urandom_range(1, 31)); reg_data = $urandom;
        end
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_in();
        reset = 1'b1; trace_ready = 1'b0;
        reg_write_sig = 1'b1; reg_num = 5'd9; reg_data = 32'hCAFE0001; wr = 1'b1; addr = 9'h33;
        tick();
        reset = 1'b0;
        clear_in();
        n_vec++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", trace_valid); end
        n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
        n_vec++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        n_vec++; if ({trace_kind, trace_tag, trace_data, trace_ts} !== '0) begin
            n_err++; $display("FAIL reset_head: got %b/%h/%h/%h want all 0", trace_kind, trace_tag, trace_data, trace_ts);
        end
    endtask

    task automatic test_basic();
        do_reset();
        trace_ready = 1'b0;
        repeat (3) tick();
        reg_write_sig = 1'b1; reg_num = 5'd5; reg_data = 32'hDEADBEEF;
        tick();
        clear_in();
        n_vec++; if (trace_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", trace_valid); end
        n_vec++; if (trace_kind !== 1'b0) begin n_err++; $display("FAIL basic_kind: got %b want 0", trace_kind); end
        n_vec++; if (trace_tag !== 9'd5) begin n_err++; $display("FAIL basic_tag: got %h want 5", trace_tag); end
        n_vec++; if (trace_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_data: got %h want deadbeef", trace_data); end
        n_vec++; if (trace_ts !== 16'd3) begin n_err++; $display("FAIL basic_ts: got %0d want 3", trace_ts); end
        n_vec++; if (level !== 5'd1) begin n_err++; $display("FAIL basic_level: got %0d want 1", level); end
    endtask

    task automatic test_filter();
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            clear_in();
            if ($urandom_range(0, 1) == 0) begin
                reg_write_sig = 1'b1; reg_num = 5'd0; reg_data = $urandom;
                wr = 1'b0;
            end else begin
                capture_en = 1'b0; wr = 1'b1; addr = 9'($urandom); wr_data = $urandom;
                reg_write_sig = 1'($urandom); reg_num = 5'($urandom_range(1, 31));
            end
            tick();
            n_vec++; if (level !== 5'd0 || trace_valid !== 1'b0) begin
                n_err++; $display("FAIL filter_level: got %0d/%b want 0/0", level, trace_valid);
            end
            n_vec++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL filter_drop: got %0d want 0", drop_count); end
        end
        clear_in();
    endtask

    task automatic test_dual();
        logic [15:0] ts0;
        do_reset();
        trace_ready = 1'b1;
        tick();
        reg_write_sig = 1'b1; reg_num = 5'd7; reg_data = 32'h11;
        wr = 1'b1; addr = 9'h40; wr_data = 32'h22;
        tick();
        clear_in();
        n_vec++; if (trace_valid !== 1'b1 || {trace_kind, trace_tag, trace_data} !== {1'b0, 9'd7, 32'h11}) begin
            n_err++; $display("FAIL dual_first: got %b %b/%h/%h want 1 0/007/00000011", trace_valid, trace_kind, trace_tag, trace_data);
        end
        ts0 = trace_ts;
        tick();
        n_vec++; if (trace_valid !== 1'b1 || {trace_kind, trace_tag, trace_data} !== {1'b1, 9'h40, 32'h22}) begin
            n_err++; $display("FAIL dual_second: got %b %b/%h/%h want 1 1/040/00000022", trace_valid, trace_kind, trace_tag, trace_data);
        end
        n_vec++; if (trace_ts !== ts0 || trace_ts !== 16'(mq[0].ts)) begin
            n_err++; $display("FAIL dual_ts: got %0d want %0d", trace_ts, ts0);
        end
        tick();
        n_vec++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL dual_empty: got %b want 0", trace_valid); end
    endtask

    task automatic test_overflow();
        logic [4:0] last_num;
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin set_single(1'($urandom)); tick(); end
        set_single(1'b0); last_num = reg_num;
        wr = 1'b1; addr = 9'($urandom); wr_data = $urandom;
        tick();
        n_vec++; if (level !== 5'd16) begin n_err++; $display("FAIL ovf_level: got %0d want 16", level); end
        n_vec++; if (drop_count !== 16'd1) begin n_err++; $display("FAIL ovf_drop1: got %0d want 1", drop_count); end
        set_single(1'b0); wr = 1'b1;
        tick();
        n_vec++; if (drop_count !== 16'd3) begin n_err++; $display("FAIL ovf_drop3: got %0d want 3", drop_count); end
        clear_in();
        trace_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_vec++; if (trace_valid !== 1'b1 || mq.size() == 0 ||
                         {trace_kind, trace_tag, trace_data, trace_ts} !== {mq[0].kind, mq[0].tag, mq[0].data, mq[0].ts}) begin
                n_err++; $display("FAIL ovf_drain%0d: got %b %b/%h/%h/%h", i, trace_valid, trace_kind, trace_tag, trace_data, trace_ts);
            end
            if (i == 15) begin
                n_vec++; if (trace_kind !== 1'b0 || trace_tag !== 9'(last_num)) begin
                    n_err++; $display("FAIL ovf_last: got %b/%h want 0/%h", trace_kind, trace_tag, 9'(last_num));
                end
            end
            tick();
        end
        n_vec++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b want 0", trace_valid); end
    endtask

    task automatic test_drop_saturation();
        trace_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin set_single(1'($urandom)); tick(); end
        set_single(1'b1);
        tick();
        while (m_drop < 65534) begin
            set_single(1'b0); wr = 1'b1;
            tick();
        end
        clear_in();
        n_vec++; if (drop_count !== 16'hFFFE) begin n_err++; $display("FAIL sat_fffe: got %h want fffe", drop_count); end
        set_single(1'b0); wr = 1'b1;
        tick();
        n_vec++; if (drop_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_plus2: got %h want ffff", drop_count); end
        set_single(1'b1);
        tick();
        clear_in();
        n_vec++; if (drop_count !== 16'hFFFF || level !== 5'd16) begin
            n_err++; $display("FAIL sat_hold: got %h/%0d want ffff/16", drop_count, level);
        end
    endtask

    task automatic test_back_to_back();
        int issued, received, cyc;
        bit prev_stall;
        logic [57:0] prev_head;
        do_reset();
        issued = 0; received = 0; cyc = 0; prev_stall = 0; prev_head = '0;
        while ((issued < 40 || mq.size() != 0) && cyc < 2000) begin
            if (mq.size() != 0) begin
                n_vec++; if (trace_valid !== 1'b1 ||
                             {trace_kind, trace_tag, trace_data, trace_ts} !== {mq[0].kind, mq[0].tag, mq[0].data, mq[0].ts}) begin
                    n_err++; $display("FAIL bp_head: got %b %b/%h/%h/%h want 1 %b/%h/%h/%h", trace_valid, trace_kind, trace_tag,
                                      trace_data, trace_ts, mq[0].kind, mq[0].tag, mq[0].data, mq[0].ts);
                end
            end else begin
                n_vec++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle: got %b want 0", trace_valid); end
            end
            if (prev_stall) begin
                n_vec++; if ({trace_kind, trace_tag, trace_data, trace_ts} !== prev_head) begin
                    n_err++; $display("FAIL bp_stable: got %h want %h", {trace_kind, trace_tag, trace_data, trace_ts}, prev_head);
                end
            end
            clear_in();
            if (issued < 40 && $urandom_range(0, 1) == 1) begin
                set_single(1'($urandom));
                issued++;
            end
            trace_ready = ($urandom_range(0, 3) != 0);
            if (trace_valid && trace_ready) received++;
            prev_stall = trace_valid && !trace_ready;
            prev_head  = {trace_kind, trace_tag, trace_data, trace_ts};
            tick();
            cyc++;
        end
        clear_in();
        n_vec++; if (cyc >= 2000) begin n_err++; $display("FAIL bp_timeout: got %0d cycles want < 2000", cyc); end
        n_vec++; if (received != 40) begin n_err++; $display("FAIL bp_count: got %0d want 40", received); end
        n_vec++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL bp_drop: got %0d want 0", drop_count); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin set_single(1'($urandom)); tick(); end
        clear_in();
        n_vec++; if (level !== 5'd6) begin n_err++; $display("FAIL rmd_fill: got %0d want 6", level); end
        trace_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++; if (trace_valid !== 1'b0 || level !== 5'd0 || drop_count !== 16'd0) begin
            n_err++; $display("FAIL rmd_state: got %b/%0d/%0d want 0/0/0", trace_valid, level, drop_count);
        end
        n_vec++; if (trace_data !== 32'd0) begin n_err++; $display("FAIL rmd_head: got %h want 0", trace_data); end
        trace_ready = 1'b0;
        set_single(1'b1);
        tick();
        clear_in();
        n_vec++; if (trace_valid !== 1'b1 || trace_ts !== 16'd0 || level !== 5'd1) begin
            n_err++; $display("FAIL rmd_ts: got %b/%0d/%0d want 1/0/1", trace_valid, trace_ts, level);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_ts = 0; m_drop = 0;
        reset = 1'b0; trace_ready = 1'b0;
        clear_in();
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_filter();
        test_dual();
        test_overflow();
        test_drop_saturation();
        test_back_to_back();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
